// File: rtl/osnt_stamp_timer.sv
// Free-running fixed-point timestamp counter with load/adjust strobes and
// N independent single-entry capture channels with overrun tracking.

module osnt_stamp_capture #(
  parameter int TW = 64
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          req,
  input  logic          ack,
  input  logic [TW-1:0] stamp_in,
  output logic          valid,
  output logic [TW-1:0] stamp,
  output logic          overrun
);
  typedef enum logic {IDLE, HELD} cap_state_t;

  cap_state_t state, state_nxt;
  logic       cap_load;
  logic       ovr_nxt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      stamp   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= ovr_nxt;
      if (cap_load) stamp <= stamp_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_load  = 1'b0;
    ovr_nxt   = overrun;
    case (state)
      IDLE: if (req) begin
        cap_load  = 1'b1;
        state_nxt = HELD;
      end
      HELD: begin
        if (req && ack) begin
          cap_load = 1'b1;
          ovr_nxt  = 1'b0;
        end else if (ack) begin
          state_nxt = IDLE;
          ovr_nxt   = 1'b0;
        end else if (req) begin
          // held stamp is kept; the newer request is the one that is lost
          ovr_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign valid = (state == HELD);
endmodule

module osnt_stamp_timer #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int FRAC_WIDTH      = 16,
  parameter int INC_WIDTH       = 32,
  parameter int NUM_CAPTURE     = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 ENABLE,
  input  logic [INC_WIDTH-1:0]                 INC_VALUE,
  input  logic                                 LOAD_EN,
  input  logic [TIMESTAMP_WIDTH-1:0]           LOAD_VALUE,
  input  logic                                 ADJ_EN,
  input  logic [TIMESTAMP_WIDTH-1:0]           ADJ_VALUE,
  output logic [TIMESTAMP_WIDTH-1:0]           STAMP_COUNTER,
  output logic                                 WRAP,
  input  logic [NUM_CAPTURE-1:0]               CAPTURE_REQ,
  input  logic [NUM_CAPTURE-1:0]               CAPTURE_ACK,
  output logic [NUM_CAPTURE-1:0]               CAPTURE_VALID,
  output logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] CAPTURE_STAMP,
  output logic [NUM_CAPTURE-1:0]               CAPTURE_OVERRUN
);
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int FW = FRAC_WIDTH;
  localparam int AW = TW + FW;

  logic [AW-1:0] acc;
  logic [AW-1:0] inc_ext;
  logic [AW-1:0] adj_ext;
  logic [AW:0]   inc_sum;
  logic          wrap_q;

  assign inc_ext = AW'(INC_VALUE);
  assign adj_ext = {ADJ_VALUE, {FW{1'b0}}};
  // extra MSB carries the wrap-around indication for the enable-only path
  assign inc_sum = {1'b0, acc} + {1'b0, inc_ext};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc    <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (LOAD_EN) begin
        acc <= {LOAD_VALUE, {FW{1'b0}}};
      end else if (ADJ_EN) begin
        acc <= acc + (ENABLE ? inc_ext : '0) + adj_ext;
      end else if (ENABLE) begin
        acc    <= inc_sum[AW-1:0];
        wrap_q <= inc_sum[AW];
      end
    end
  end

  assign STAMP_COUNTER = acc[AW-1:FW];
  assign WRAP          = wrap_q;

  for (genvar i = 0; i < NUM_CAPTURE; i++) begin : g_cap
    osnt_stamp_capture #(.TW(TW)) u_cap (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .req      (CAPTURE_REQ[i]),
      .ack      (CAPTURE_ACK[i]),
      .stamp_in (STAMP_COUNTER),
      .valid    (CAPTURE_VALID[i]),
      .stamp    (CAPTURE_STAMP[i*TW +: TW]),
      .overrun  (CAPTURE_OVERRUN[i])
    );
  end
endmodule

// File: doc/osnt_stamp_timer.md
OSNT_STAMP_TIMER -- requirements
Module: osnt_stamp_timer

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64, meaning width of the visible timestamp (TW).
REQ-002 SHALL have parameter FRAC_WIDTH, default 16, meaning number of fractional bits in the internal accumulator and in INC_VALUE (FW).
REQ-003 SHALL have parameter INC_WIDTH, default 32, meaning INC_VALUE width; INC_WIDTH > FRAC_WIDTH.
REQ-004 SHALL have parameter NUM_CAPTURE, default 4, meaning number of independent capture channels (N).
REQ-005 SHALL have port ACLK  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port ARESET  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ENABLE  input  1  high = accumulator advances by INC_VALUE each cycle.
REQ-008 SHALL have port INC_VALUE  input  INC_WIDTH  unsigned fixed-point increment, low FW bits fractional.
REQ-009 SHALL have port LOAD_EN  input  1  one-cycle strobe: overwrite time.
REQ-010 SHALL have port LOAD_VALUE  input  TW  integer time to load.
REQ-011 SHALL have port ADJ_EN  input  1  one-cycle strobe: apply offset.
REQ-012 SHALL have port ADJ_VALUE  input  TW  two's-complement integer offset.
REQ-013 SHALL have port STAMP_COUNTER  output  TW  current integer time, registered.
REQ-014 SHALL have port WRAP  output  1  one-cycle pulse on counter wrap-around.
REQ-015 SHALL have port CAPTURE_REQ  input  N  per-channel capture strobe.
REQ-016 SHALL have port CAPTURE_ACK  input  N  per-channel consumer acknowledge.
REQ-017 SHALL have port CAPTURE_VALID  output  N  per-channel held-stamp valid.
REQ-018 SHALL have port CAPTURE_STAMP  output  N*TW  channel i in bits [i*TW +: TW].
REQ-019 SHALL have port CAPTURE_OVERRUN  output  N  per-channel sticky lost-request flag.

Function
REQ-020 Accumulator ACC SHALL be TW+FW bits; STAMP_COUNTER SHALL equal ACC[TW+FW-1:FW] at all times, all arithmetic modulo 2^(TW+FW).
REQ-021 Per-cycle update priority SHALL be: ARESET > LOAD_EN > ADJ_EN > ENABLE > hold.
REQ-022 LOAD_EN: ACC <= {LOAD_VALUE, FW zeros}; no increment that cycle; visible on STAMP_COUNTER next cycle.
REQ-023 ADJ_EN: ACC <= ACC + (ENABLE ? INC_VALUE : 0) + {sign-extended-free ADJ_VALUE, FW zeros}, i.e. the tick is not lost.
REQ-024 ENABLE only: ACC <= ACC + INC_VALUE zero-extended; ENABLE low with no strobe: ACC holds.
REQ-025 WRAP SHALL pulse high for exactly the cycle after an ENABLE-only update whose unsigned sum carried out of bit TW+FW-1; never on load or adjust.
REQ-026 INC_VALUE = 0 with ENABLE high SHALL hold ACC and SHALL NOT pulse WRAP.
REQ-027 Each capture channel SHALL be an independent FSM with states IDLE and HELD.
REQ-028 IDLE + REQ: CAPTURE_STAMP[i] <= STAMP_COUNTER value present in the REQ cycle (pre-update), VALID <= 1, -> HELD; latency 1 cycle.
REQ-029 IDLE + ACK without REQ: ignored, no state change.
REQ-030 HELD, no REQ, no ACK: stamp and VALID held.
REQ-031 HELD + ACK, no REQ: VALID <= 0, OVERRUN <= 0, -> IDLE.
REQ-032 HELD + REQ, no ACK: stamp NOT overwritten, OVERRUN <= 1 (sticky), stay HELD.
REQ-033 HELD + REQ + ACK same cycle: new stamp captured, VALID stays 1, OVERRUN <= 0, stay HELD.
REQ-034 Simultaneous REQ on multiple channels SHALL capture the identical STAMP_COUNTER value.
REQ-035 Capture SHALL sample STAMP_COUNTER regardless of LOAD_EN/ADJ_EN in the same cycle (pre-update value).

Reset
REQ-036 ARESET high at a rising edge SHALL set ACC, STAMP_COUNTER, WRAP, CAPTURE_VALID, CAPTURE_STAMP, CAPTURE_OVERRUN to 0 and all FSMs to IDLE, overriding every other input.
REQ-037 ARESET mid-operation (channel HELD, strobes active) SHALL discard held stamps and pending strobes; normal operation resumes the first cycle after ARESET deasserts.

Verification
REQ-038 Reset, ENABLE=1, INC_VALUE=1<<16 (FW=16), 10 cycles -> STAMP_COUNTER 0,1,...,10 consecutively.
REQ-039 INC_VALUE=0x8000 (0.5), ENABLE=1 -> STAMP_COUNTER increments every 2nd cycle; INC_VALUE=0 -> frozen, no WRAP.
REQ-040 LOAD_VALUE=2^64-2, INC=1<<16 -> next cycles FFFF...FFFE, FFFF...FFFF, 0 with WRAP high in the cycle showing 0 only; LOAD and ADJ same cycle -> LOAD wins.
REQ-041 Counter at 100, INC=1<<16, ADJ_VALUE=-10 -> next value 91; ADJ_VALUE=+5 from 100 -> 106.
REQ-042 Channel 0 REQ at time 50 -> VALID[0]=1, STAMP[0]=50 next cycle; REQ at 60 without ACK -> STAMP[0] stays 50, OVERRUN[0]=1; ACK -> VALID[0]=0, OVERRUN[0]=0; REQ+ACK in HELD -> new stamp, VALID stays 1.
REQ-043 ARESET asserted while channels HELD with OVERRUN set -> all VALID/OVERRUN/STAMP 0 and STAMP_COUNTER 0 next cycle.
